// File: rtl/flatten_l2.sv
// flatten_l2: layer-2 flatten stage. Reads the two 32x32 pooled channel
// memories (layer-1 kernel 0 and kernel 1) over the shared layer-memory bus
// and writes them into layer-2 memory with the channels interleaved:
// L2[2i] = K0[i], L2[2i+1] = K1[i]. Each word costs three cycles
// (READ, LATCH, WRITE).
// Optional build macro FLATTEN_CHECKSUM_EN adds a 24-bit running sum of the
// written words on port checksum.
module flatten_l2 #(
  parameter int          N_PIX     = 1024,
  parameter logic [2:0]  SEL_L1_K0 = 3'b011,
  parameter logic [2:0]  SEL_L1_K1 = 3'b100,
  parameter logic [2:0]  SEL_L2    = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
`ifdef FLATTEN_CHECKSUM_EN
  output logic [23:0] checksum,
`endif
  output logic [2:0]  csel
);

  localparam int IDXW = $clog2(N_PIX);

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, FIN} state_t;

  state_t          st, st_n;
  logic [IDXW-1:0] idx, idx_n;
  logic            ch, ch_n;
  logic [19:0]     dlat;

  // Output values for the state being entered; registered below so that
  // every port comes straight from a flop and lines up with its state.
  logic        busy_n, done_n, crd_n, cwr_n;
  logic [11:0] caddr_rd_n, caddr_wr_n;
  logic [19:0] cdata_wr_n;
  logic [2:0]  csel_n;

  // Next-state, counter and next-output decode
  always_comb begin
    st_n  = st;
    idx_n = idx;
    ch_n  = ch;
    unique case (st)
      IDLE:  if (start) begin
               st_n  = READ;
               idx_n = '0;
               ch_n  = 1'b0;
             end
      READ:  st_n = LATCH;
      LATCH: st_n = WRITE;
      WRITE: begin
        if (!ch) begin
          ch_n = 1'b1;
          st_n = READ;
        end else if (idx != IDXW'(N_PIX - 1)) begin
          ch_n  = 1'b0;
          idx_n = idx + 1'b1;
          st_n  = READ;
        end else begin
          st_n = FIN;
        end
      end
      FIN:     st_n = IDLE;
      default: st_n = IDLE;
    endcase

    busy_n     = (st_n != IDLE);
    done_n     = (st_n == FIN);
    crd_n      = (st_n == READ);
    cwr_n      = (st_n == WRITE);
    caddr_rd_n = '0;
    caddr_wr_n = '0;
    cdata_wr_n = '0;
    csel_n     = 3'b000;
    unique case (st_n)
      READ: begin
        caddr_rd_n = {2'b00, idx_n[9:0]};
        csel_n     = ch_n ? SEL_L1_K1 : SEL_L1_K0;
      end
      LATCH: csel_n = ch_n ? SEL_L1_K1 : SEL_L1_K0;
      WRITE: begin
        caddr_wr_n = {1'b0, idx_n[9:0], ch_n};
        // Read data is valid during LATCH, the same cycle it is latched, so
        // the write word is the value being captured into dlat.
        cdata_wr_n = cdata_rd;
        csel_n     = SEL_L2;
      end
      default: ;
    endcase
  end

  // State, counters, data latch and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      idx      <= '0;
      ch       <= 1'b0;
      dlat     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= 3'b000;
    end else begin
      st       <= st_n;
      idx      <= idx_n;
      ch       <= ch_n;
      if (st == LATCH) dlat <= cdata_rd;
      busy     <= busy_n;
      done     <= done_n;
      crd      <= crd_n;
      cwr      <= cwr_n;
      caddr_rd <= caddr_rd_n;
      caddr_wr <= caddr_wr_n;
      cdata_wr <= cdata_wr_n;
      csel     <= csel_n;
    end
  end

`ifdef FLATTEN_CHECKSUM_EN
  // Running sum of written words; cleared on an accepted start, so it holds
  // its final value from done until the next run begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    checksum <= '0;
    else if (st == IDLE && start) checksum <= '0;
    else if (st == WRITE)         checksum <= checksum + {4'b0000, cdata_wr};
  end
`endif

endmodule

// File: tb/tb_flatten_l2.sv
// Bench for flatten_l2: behavioural layer memories, a scoreboard of expected
// L2 writes, and directed runs covering timing, double start and mid-run reset.
module tb_flatten_l2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd = '0;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;
`ifdef FLATTEN_CHECKSUM_EN
  logic [23:0] checksum;
`endif

  flatten_l2 dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
`ifdef FLATTEN_CHECKSUM_EN
    .checksum(checksum),
`endif
    .csel(csel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [19:0] data;
  } wr_t;

  logic [19:0] k0 [1024];
  logic [19:0] k1 [1024];
  wr_t         q [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          last_wr_cyc = 0;
  logic [11:0] last_wr_addr = '0;
  logic [23:0] exp_cks = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Layer-1 memories: data returned the cycle after crd
  always @(posedge clk)
    if (crd) cdata_rd <= (csel == 3'b011) ? k0[caddr_rd[9:0]] :
                         (csel == 3'b100) ? k1[caddr_rd[9:0]] : 20'h0;

  // Bus monitor: scoreboard on writes, strobe exclusivity, done counting
  always @(negedge clk) begin
    if (!reset) begin
      chk("excl", {11'd0, crd & cwr, crd ? 12'd0 : caddr_rd, cwr ? 12'd0 : caddr_wr}, 32'd0);
      if (cwr) begin
        chk("wr_csel", {29'd0, csel}, 32'd5);
        if (q.size() == 0) chk("wr_unexpected", {20'd0, caddr_wr}, 32'hFFFFFFFF);
        else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", {20'd0, caddr_wr}, {20'd0, e.addr});
          chk("wr_data", {12'd0, cdata_wr}, {12'd0, e.data});
        end
        last_wr_cyc  = cyc;
        last_wr_addr = caddr_wr;
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_exp();
    q.delete();
    exp_cks = '0;
    for (int i = 0; i < 1024; i++) begin
      q.push_back({12'(2*i),   k0[i]});
      q.push_back({12'(2*i+1), k1[i]});
      exp_cks = exp_cks + {4'd0, k0[i]} + {4'd0, k1[i]};
    end
    done_cnt = 0;
  endtask

  function automatic logic [31:0] outs_vec();
    return {busy, done, crd, cwr, csel, caddr_rd | caddr_wr, 12'd0} | {12'd0, cdata_wr};
  endfunction

  task automatic run(input bit dbl_start);
    int t0;
    load_exp();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
    chk("t1_crd", {31'd0, crd}, 32'd1);
    chk("t1_addr", {20'd0, caddr_rd}, 32'd0);
    chk("t1_csel", {29'd0, csel}, 32'd3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t2_crd", {31'd0, crd}, 32'd0);
    chk("t2_csel", {29'd0, csel}, 32'd3);
    @(negedge clk);
    chk("t3_cwr", {31'd0, cwr}, 32'd1);
    chk("t3_addr", {20'd0, caddr_wr}, 32'd0);
    @(negedge clk);
    chk("t4_crd", {31'd0, crd}, 32'd1);
    chk("t4_csel", {29'd0, csel}, 32'd4);
    chk("t4_addr", {20'd0, caddr_rd}, 32'd0);
    while (!done && cyc < t0 + 7000) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      start = dbl_start && (cyc == t0 + 499);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("done_cyc", cyc - t0, 32'd6144);
    chk("last_addr", {20'd0, last_wr_addr}, 32'h7FF);
    chk("last_wr_cyc", last_wr_cyc - t0, 32'd6143);
`ifdef FLATTEN_CHECKSUM_EN
    chk("cks_done", {8'd0, checksum}, {8'd0, exp_cks});
`endif
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("done_cnt", done_cnt, 32'd1);
    chk("q_empty", q.size(), 32'd0);
`ifdef FLATTEN_CHECKSUM_EN
    repeat (3) @(negedge clk);
    chk("cks_stable", {8'd0, checksum}, {8'd0, exp_cks});
`endif
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 1024; i++) begin
      k0[i] = 20'(i);
      k1[i] = 20'h80000 | 20'(i);
    end
    // Reset, then idle with no start
    repeat (2) @(negedge clk);
    chk("rst_outs", outs_vec(), 32'd0);
`ifdef FLATTEN_CHECKSUM_EN
    chk("rst_cks", {8'd0, checksum}, 32'd0);
`endif
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_outs", outs_vec(), 32'd0);
    end

    // Basic ordering and cycle timing
    run(1'b0);

    // Second start while busy is ignored
    for (int i = 0; i < 1024; i++) begin
      k0[i] = 20'($urandom);
      k1[i] = 20'($urandom);
    end
    run(1'b1);

    // Reset mid-run
    load_exp();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 2000) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_outs", outs_vec(), 32'd0);
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("midrst_idle", outs_vec(), 32'd0);
    end
    chk("midrst_nodone", done_cnt, 32'd0);
    for (int i = 0; i < 1024; i++) begin
      k0[i] = 20'(1023 - i) ^ 20'h5A5A5;
      k1[i] = 20'(i) ^ 20'hA5A5A;
    end
    run(1'b0);

`ifdef FLATTEN_CHECKSUM_EN
    for (int i = 0; i < 1024; i++) begin
      k0[i] = 20'hFFFFF;
      k1[i] = 20'hFFFFF;
    end
    run(1'b0);
    chk("cks_ones", {8'd0, checksum}, 32'h00FFF800);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flatten_l2.md
Name: flatten_l2

Overview:
- Layer-2 stage, directly downstream of the conv/max-pool stage.
- Starts once both 32x32 max-pool result memories are written (layer-1, kernel 0 and kernel 1).
- Reads them from the shared layer memory interface and writes a 2048-word flattened vector to layer-2 memory, channels interleaved: L2[2i]=K0[i], L2[2i+1]=K1[i].
- Shares the crd/cwr/csel bus with the upstream stage; the top level muxes the bus by which stage is busy.

Parameters:
- N_PIX, 1024, pixels per pooled channel (32x32); counter width is clog2(N_PIX).
- SEL_L1_K0, 3'b011, csel of layer-1 kernel-0 memory.
- SEL_L1_K1, 3'b100, csel of layer-1 kernel-1 memory.
- SEL_L2, 3'b101, csel of layer-2 flatten memory.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse from upstream when pooling is complete
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final write
- crd  out  1  layer-memory read strobe
- caddr_rd  out  12  read address
- cdata_rd  in  20  read data, valid the cycle after crd=1 is presented
- cwr  out  1  layer-memory write strobe
- caddr_wr  out  12  write address
- cdata_wr  out  20  write data
- csel  out  3  memory select; 3'b000 when idle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values: all outputs 0; internal state IDLE, idx=0, ch=0, data latch=0.
- All outputs are registered.
- FSM states: IDLE, READ, LATCH, WRITE, FIN.
  - IDLE: start=1 -> READ; idx=0, ch=0, busy<=1. Otherwise stay; start=0 is ignored.
  - READ: crd=1, cwr=0, csel=ch?SEL_L1_K1:SEL_L1_K0, caddr_rd={2'b00,idx[9:0]} -> LATCH.
  - LATCH: crd=0, csel held, latch cdata_rd -> WRITE.
  - WRITE: cwr=1, csel=SEL_L2, caddr_wr={1'b0,idx[9:0],ch}, cdata_wr=latched word, passed unmodified (no sign or width change).
    - ch=0: ch<=1 -> READ.
    - ch=1, idx<N_PIX-1: ch<=0, idx<=idx+1 -> READ.
    - ch=1, idx=N_PIX-1: -> FIN.
  - FIN: cwr=0, csel=0, done=1 for exactly one cycle, busy<=0 -> IDLE.
- Strobe exclusivity: crd and cwr never both high; caddr_rd/caddr_wr return to 0 when the corresponding strobe is low.
- Timing: 3 cycles per word, 6 per pixel. First write is asserted 3 cycles after the start edge; done follows 6144 cycles of work.
- Boundaries and events:
  - start while busy: ignored, no restart.
  - idx wraps only via IDLE, never mid-run.
  - Final address written is 12'h7FF.
  - Reset mid-operation: immediate return to reset values; no done pulse; a partially written L2 is acceptable.

Optional Feature:
- Macro FLATTEN_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [23:0].
  - Cleared when start is accepted.
  - Adds zero-extended cdata_wr on every WRITE cycle, modulo 2^24.
  - Final value is stable from the done pulse until the next accepted start.
  - Reset value 0.
- Undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold reset 2 cycles, no start -> all outputs 0, busy=0, no strobes for 100 cycles.
- Basic ordering: K0[i]=i, K1[i]=20'h80000|i, pulse start -> L2[2i]=i, L2[2i+1]=20'h80000|i for all i; done pulse exactly once; busy high throughout.
- Cycle timing: pulse start at cycle T:
  - crd=1 at T+1 with caddr_rd=0, csel=3.
  - cwr=1 at T+3 with caddr_wr=0.
  - First K1 read at T+4 with csel=4.
  - Last write caddr_wr=12'h7FF.
  - done one cycle after the last write.
- start while busy: second start pulse at cycle 500 -> no restart, same output and done timing as the single-start case.
- Reset mid-run: assert reset at cycle 2000 -> outputs 0 the same cycle, no done pulse. A following start performs a full, correct flatten.
- FLATTEN_CHECKSUM_EN: all words 20'hFFFFF -> checksum = 2048*0xFFFFF mod 2^24 = 24'hFFF800 at done.
